// File: rtl/led_fade_driver.sv
// LED fade driver: each channel's brightness ramps toward its PIO on/off target and is rendered by a shared PWM counter.
// Optional macro LED_GAMMA_EN replaces the linear duty curve with an approximately quadratic one.
module led_fade_driver #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);

  logic [NUM_LEDS-1:0] pattern_q;
  logic [PWM_BITS-1:0] level  [NUM_LEDS];
  logic [PWM_BITS-1:0] target [NUM_LEDS];
  logic [PWM_BITS-1:0] cmp    [NUM_LEDS];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                tick;

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      target[i] = pattern_q[i] ? LVL_MAX : '0;
    end
  end

  assign tick = enable && (step_cnt == STEP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      pwm_cnt   <= '0;
      step_cnt  <= '0;
    end else begin
      pattern_q <= pattern_in;
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + LVL_ONE;
      if (!enable || tick) begin
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + STEP_ONE;
      end
    end
  end

  // Bypass snaps levels to target so re-enabling fade starts without a ramp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (!enable) begin
          level[i] <= target[i];
        end else if (tick) begin
          if (pattern_q[i] && (level[i] != LVL_MAX)) begin
            level[i] <= level[i] + LVL_ONE;
          end else if (!pattern_q[i] && (level[i] != '0)) begin
            level[i] <= level[i] - LVL_ONE;
          end
        end
      end
    end
  end

`ifdef LED_GAMMA_EN
  localparam int PROD_W = 2 * PWM_BITS;
  logic [PROD_W-1:0] prod [NUM_LEDS];

  // level*(level+1)>>PWM_BITS keeps both endpoints exact (0 and MAX).
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      prod[i] = {{PWM_BITS{1'b0}}, level[i]} * ({{PWM_BITS{1'b0}}, level[i]} + PROD_W'(1));
      cmp[i]  = prod[i][PROD_W-1:PWM_BITS];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      cmp[i] = level[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_out[i] <= enable ? (cmp[i] > pwm_cnt) : pattern_q[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      busy = busy | (level[i] != target[i]);
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver (PWM_BITS=4, STEP_DIV=2); a second slow-stepping instance holds
// intermediate levels long enough to measure their PWM duty in both the linear and LED_GAMMA_EN builds.
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pattern_in = 8'h00;
  logic       enable = 1'b1;
  logic [7:0] led_out;
  logic       busy;
  logic [7:0] slow_pattern = 8'h00;
  logic       slow_enable = 1'b1;
  logic [7:0] slow_led;
  logic       slow_busy;

  int vec_cnt = 0;
  int miscompares = 0;

  led_fade_driver #(.NUM_LEDS(8), .PWM_BITS(4), .STEP_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .enable(enable),
    .led_out(led_out), .busy(busy)
  );

  led_fade_driver #(.NUM_LEDS(8), .PWM_BITS(4), .STEP_DIV(100)) dut_slow (
    .clk(clk), .reset_n(reset_n), .pattern_in(slow_pattern), .enable(slow_enable),
    .led_out(slow_led), .busy(slow_busy)
  );

  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] pat, input logic en);
    pattern_in = pat;
    enable     = en;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_cnt++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Counts slow_led[0] high samples over 15 consecutive cycles (one PWM period).
  task automatic countSlowHigh(output int cnt);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (slow_led[0] === 1'b1) cnt++;
      waitCycles(1);
    end
  endtask

  int cnt;
  int lo_bound;
  int exp_l3, exp_l5, exp_l8;

  initial begin
`ifdef LED_GAMMA_EN
    exp_l3 = 0; exp_l5 = 1; exp_l8 = 4;
    lo_bound = 0;
`else
    exp_l3 = 3; exp_l5 = 5; exp_l8 = 8;
    lo_bound = 1;
`endif

    // Test 1: idle after reset
    waitCycles(2);
    reset_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      waitCycles(1);
      checkOutput("idle", {23'd0, led_out, busy}, {23'd0, 8'h00, 1'b0});
    end

    // Tests 3 and 7: slow instance holds levels 3, 5 and 8 for 100 cycles each
    reset_n = 1'b0;
    slow_pattern = 8'h01;
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(320);
    countSlowHigh(cnt);
    checkOutput("duty_level3", cnt, exp_l3);
    waitCycles(185);
    countSlowHigh(cnt);
    checkOutput("duty_level5", cnt, exp_l5);
    waitCycles(285);
    countSlowHigh(cnt);
    checkOutput("duty_level8", cnt, exp_l8);
    checkOutput("slow_busy", slow_busy, 1'b1);
    checkOutput("slow_other_leds", slow_led[7:1], 7'h00);

    // Test 2: full fade-in of channel 0
    applyStimulus(8'h01, 1'b1);
    waitCycles(2);
    checkOutput("fade_in_busy", busy, 1'b1);
    waitCycles(40);
    for (int k = 0; k < 15; k++) begin
      checkOutput("full_on", {23'd0, led_out, busy}, {23'd0, 8'h01, 1'b0});
      waitCycles(1);
    end

    // Test 4: partial ramp up, then reverse without a jump
    applyStimulus(8'h00, 1'b1);
    waitCycles(40);
    checkOutput("fade_out_done", {23'd0, led_out, busy}, {23'd0, 8'h00, 1'b0});
    applyStimulus(8'h01, 1'b1);
    waitCycles(16);
    checkOutput("mid_ramp_busy", busy, 1'b1);
    applyStimulus(8'h00, 1'b1);
    waitCycles(1);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (led_out[0] === 1'b1) cnt++;
      waitCycles(1);
    end
    checkOutput("reverse_duty_in_range", {31'd0, (cnt >= lo_bound) && (cnt <= 10)}, 32'd1);
    waitCycles(30);
    for (int k = 0; k < 15; k++) begin
      checkOutput("reverse_settled", {23'd0, led_out, busy}, {23'd0, 8'h00, 1'b0});
      waitCycles(1);
    end

    // Test 5: bypass then re-enable without a ramp
    applyStimulus(8'hA5, 1'b0);
    waitCycles(2);
    checkOutput("bypass", {23'd0, led_out, busy}, {23'd0, 8'hA5, 1'b0});
    applyStimulus(8'hA5, 1'b1);
    for (int k = 0; k < 15; k++) begin
      waitCycles(1);
      checkOutput("reenable_no_ramp", {23'd0, led_out, busy}, {23'd0, 8'hA5, 1'b0});
    end

    // Test 6: asynchronous reset mid-ramp, then a ramp restarting from level 0
    applyStimulus(8'h00, 1'b0);
    waitCycles(3);
    applyStimulus(8'h01, 1'b1);
    waitCycles(10);
    checkOutput("pre_reset_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset", {23'd0, led_out, busy}, {23'd0, 8'h00, 1'b0});
    waitCycles(2);
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      waitCycles(1);
      checkOutput("restart_from_zero", {24'd0, led_out}, (k == 16) ? 32'h01 : 32'h00);
    end
    checkOutput("restart_busy", busy, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream of the 8-bit LED output PIO.
- Consumes the PIO's registered on/off pattern and drives the board LED pins.
- Each LED fades smoothly toward its commanded state: per-channel brightness level ramps up or down and is rendered by a shared PWM counter.
- Same clock domain as the PIO; no bus interface.

Parameters:
- NUM_LEDS, 8, number of LED channels (width of pattern_in and led_out).
- PWM_BITS, 8, brightness resolution; MAX = 2^PWM_BITS - 1.
- STEP_DIV, 50000, clk cycles per brightness step (legal range >= 1).

Ports:
- clk  input  1  system clock, same as the PIO.
- reset_n  input  1  asynchronous, active-low reset.
- pattern_in  input  NUM_LEDS  target on/off pattern from PIO out_port.
- enable  input  1  1 = fade mode; 0 = direct bypass.
- led_out  output  NUM_LEDS  registered LED drive, active high.
- busy  output  1  high while any channel's level differs from its target.

Behaviour:
- Reset values: all state clears to 0 (pattern_q, all level[i], pwm_cnt, step_cnt, led_out, busy). Reset is asynchronous, so led_out goes to 0 immediately, including mid-ramp.
- Input stage: pattern_in is registered into pattern_q every cycle. target[i] = pattern_q[i] ? MAX : 0.
- PWM counter:
  - pwm_cnt counts 0..MAX-1, then wraps to 0. Period is MAX cycles; free-running whenever out of reset.
  - Compare value cmp[i] = level[i], unless modified by the optional feature.
- Output register: led_out[i] <= enable ? (cmp[i] > pwm_cnt) : pattern_q[i].
  - level 0 gives a constant 0; level MAX gives a constant 1.
  - Duty cycle is level/MAX.
- Step divider:
  - step_cnt counts 0..STEP_DIV-1 and wraps. tick = (step_cnt == STEP_DIV-1).
  - STEP_DIV=1 gives a tick every cycle.
  - step_cnt is held at 0 while enable=0.
- Level update, per channel, on tick with enable=1:
  - pattern_q[i]=1 and level<MAX: level+1.
  - pattern_q[i]=0 and level>0: level-1.
  - Otherwise level holds. Saturating; never wraps.
- Target change mid-ramp: direction reverses from the current level with no jump. Several channels ramp independently on the same tick.
- enable=0: every level[i] <= target[i] each cycle, so levels snap. Returning to enable=1 therefore starts without a ramp.
- busy = OR over i of (level[i] != target[i]). Combinational from registers; 0 whenever enable=0 has been held for at least 1 cycle.
- Latency:
  - pattern_in -> pattern_q: 1 cycle.
  - First level change: at the next tick.
  - Level -> led_out: 1 cycle through the output register.
  - Bypass latency pattern_in -> led_out: 2 cycles.
- Full fade 0 -> MAX takes MAX ticks, i.e. MAX*STEP_DIV cycles plus alignment to the first tick.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: cmp[i] = (level[i] * (level[i] + 1)) >> PWM_BITS.
  - Gives an approximately quadratic perceived-brightness curve.
  - Endpoints are exact: level 0 -> 0, level MAX -> MAX.
  - Uses a (2*PWM_BITS)-bit product per channel, or one shared multiplier time-multiplexed across channels; either way led_out latency is unchanged.
- Not defined: cmp[i] = level[i], giving linear duty. No multiplier is present.
- Bypass mode, busy and level behaviour are identical in both builds.

Test Plan:
Bench configuration: PWM_BITS=4 (MAX=15), STEP_DIV=2, NUM_LEDS=8.
1. Reset release with pattern_in=8'h00, enable=1, run 200 cycles -> led_out=8'h00, busy=0 throughout.
2. pattern_in=8'h01 -> busy=1 two cycles later; level[0] reaches 15 after 15 ticks (about 30 cycles) -> then led_out[0]=1 for a full 15-cycle period, busy=0, led_out[7:1]=0.
3. Hold level[0]=5 (force via STEP_DIV large, or sample mid-ramp) -> led_out[0] high exactly 5 of 15 cycles per PWM period.
4. Ramp 8'h01 up to level 8, then set pattern_in=8'h00 -> level steps 8,7,...,0 with no jump -> led_out[0]=0 constantly, busy=0.
5. enable=0, pattern_in=8'hA5 -> led_out=8'hA5 two cycles later, busy=0; set enable=1 -> led_out stays 8'hA5 with no ramp.
6. Assert reset_n low mid-ramp, asynchronously between clk edges -> led_out=0 and busy=0 immediately; after release the ramp restarts from level 0.
7. Gamma build (LED_GAMMA_EN defined) -> level 15 gives constant on; level 3 gives cmp=0 (constant off); level 8 gives cmp=4, i.e. 4/15 duty.
